// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings and reserved range for alu_unit
// Purpose: shared opcode constants for the ALU datapath, top and bench.
// Ports: none (package).
package alu_pkg;

    localparam int OPCODE_W = 5;

    localparam logic [OPCODE_W-1:0] OP_ADD   = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_SUB   = 5'b00001;
    localparam logic [OPCODE_W-1:0] OP_MUL   = 5'b00010;
    localparam logic [OPCODE_W-1:0] OP_DIV   = 5'b00011;
    localparam logic [OPCODE_W-1:0] OP_MOD   = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_AND   = 5'b00101;
    localparam logic [OPCODE_W-1:0] OP_OR    = 5'b00110;
    localparam logic [OPCODE_W-1:0] OP_XOR   = 5'b00111;
    localparam logic [OPCODE_W-1:0] OP_NAND  = 5'b01000;
    localparam logic [OPCODE_W-1:0] OP_NOR   = 5'b01001;
    localparam logic [OPCODE_W-1:0] OP_XNOR  = 5'b01010;
    localparam logic [OPCODE_W-1:0] OP_NOT   = 5'b01011;
    localparam logic [OPCODE_W-1:0] OP_NEG   = 5'b01100;
    localparam logic [OPCODE_W-1:0] OP_SLL   = 5'b01101;
    localparam logic [OPCODE_W-1:0] OP_SRL   = 5'b01110;
    localparam logic [OPCODE_W-1:0] OP_SRA   = 5'b01111;
    localparam logic [OPCODE_W-1:0] OP_SLT   = 5'b10000;
    localparam logic [OPCODE_W-1:0] OP_SLTU  = 5'b10001;
    localparam logic [OPCODE_W-1:0] OP_INC   = 5'b10010;
    localparam logic [OPCODE_W-1:0] OP_DEC   = 5'b10011;
    localparam logic [OPCODE_W-1:0] OP_ROTL  = 5'b10100;
    localparam logic [OPCODE_W-1:0] OP_ROTR  = 5'b10101;
    localparam logic [OPCODE_W-1:0] OP_PASSA = 5'b10110;
    localparam logic [OPCODE_W-1:0] OP_PASSB = 5'b10111;

    // Opcodes 11000..11111 are reserved and produce the all-clear result.
    localparam logic [OPCODE_W-1:0] OP_RSVD_LO = 5'b11000;
    localparam logic [OPCODE_W-1:0] OP_RSVD_HI = 5'b11111;

    function automatic logic is_reserved(input logic [OPCODE_W-1:0] op);
        return (op >= OP_RSVD_LO) && (op <= OP_RSVD_HI);
    endfunction

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/result bundle between the issuing stage and alu_unit
// Purpose: groups operands, opcode, registered result and flags.
// Signals: a, b, opcode (master -> slave); result, zero, carry_out,
//          overflow (slave -> master).
interface alu_if #(
    parameter int WIDTH = 16
);
    import alu_pkg::*;

    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [OPCODE_W-1:0] opcode;
    logic [WIDTH-1:0]    result;
    logic                zero;
    logic                carry_out;
    logic                overflow;

    modport master (
        output a, b, opcode,
        input  result, zero, carry_out, overflow
    );

    modport slave (
        input  a, b, opcode,
        output result, zero, carry_out, overflow
    );

endinterface

// File: rtl/alu_datapath.sv
// rtl/alu_datapath.sv - combinational next-result and flag logic for alu_unit
// Purpose: computes result/zero/carry/overflow from operands and opcode.
// Config: ALU_DIV_EN enables the DIV/MOD opcodes; otherwise they fall into
//         the default (all-clear) case.
// Ports: a_i, b_i (WIDTH), opcode_i (5) in; result_o (WIDTH), zero_o,
//        carry_o, overflow_o out.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]    a_i,
    input  logic [WIDTH-1:0]    b_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic [WIDTH-1:0]    result_o,
    output logic                zero_o,
    output logic                carry_o,
    output logic                overflow_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // One extra bit holds the carry (ADD) or borrow (SUB).
    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] diff_ext;

    assign sum_ext  = {1'b0, a_i} + {1'b0, b_i};
    assign diff_ext = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        result_o   = '0;
        carry_o    = 1'b0;
        overflow_o = 1'b0;
        case (opcode_i)
            OP_ADD: begin
                result_o   = sum_ext[WIDTH-1:0];
                carry_o    = sum_ext[WIDTH];
                overflow_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                             (sum_ext[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                result_o   = diff_ext[WIDTH-1:0];
                carry_o    = diff_ext[WIDTH];
                overflow_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                             (diff_ext[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_MUL:   result_o = a_i * b_i;
`ifdef ALU_DIV_EN
            OP_DIV:   result_o = (b_i == '0) ? '0 : a_i / b_i;
            OP_MOD:   result_o = (b_i == '0) ? '0 : a_i % b_i;
`endif
            OP_AND:   result_o = a_i & b_i;
            OP_OR:    result_o = a_i | b_i;
            OP_XOR:   result_o = a_i ^ b_i;
            OP_NAND:  result_o = ~(a_i & b_i);
            OP_NOR:   result_o = ~(a_i | b_i);
            OP_XNOR:  result_o = ~(a_i ^ b_i);
            OP_NOT:   result_o = ~a_i;
            OP_NEG:   result_o = ~a_i + ONE;
            // Shift by the full value of b: amounts >= WIDTH shift everything
            // out (zeros, or sign copies for SRA).
            OP_SLL:   result_o = a_i << b_i;
            OP_SRL:   result_o = a_i >> b_i;
            OP_SRA:   result_o = $unsigned($signed(a_i) >>> b_i);
            OP_SLT:   result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLTU:  result_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            OP_INC: begin
                result_o = a_i + ONE;
                carry_o  = &a_i;
            end
            OP_DEC: begin
                result_o = a_i - ONE;
                carry_o  = (a_i == '0);
            end
            OP_ROTL:  result_o = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
            OP_ROTR:  result_o = {a_i[0], a_i[WIDTH-1:1]};
            OP_PASSA: result_o = a_i;
            OP_PASSB: result_o = b_i;
            default: begin
                result_o   = '0;
                carry_o    = 1'b0;
                overflow_o = 1'b0;
            end
        endcase
        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - registered integer ALU, one operation per cycle
// Purpose: execute-stage ALU; registers alu_datapath outputs, 1-cycle latency.
// Config: ALU_DIV_EN (see alu_datapath) enables DIV/MOD.
// Ports: clk, rst (sync, active-high); bus (alu_if.slave): a, b, opcode in;
//        result, zero, carry_out, overflow out (registered).
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    logic [WIDTH-1:0] result_d, result_q;
    logic             zero_d, zero_q;
    logic             carry_d, carry_q;
    logic             overflow_d, overflow_q;

    alu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .a_i        (bus.a),
        .b_i        (bus.b),
        .opcode_i   (bus.opcode),
        .result_o   (result_d),
        .zero_o     (zero_d),
        .carry_o    (carry_d),
        .overflow_o (overflow_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q   <= '0;
            zero_q     <= 1'b1;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - self-checking bench for alu_unit (WIDTH=16)
module tb_alu_unit;
    import alu_pkg::*;

    typedef struct packed {
        logic [15:0] r;
        logic        z;
        logic        c;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_if #(.WIDTH(16)) bus ();

    alu_unit #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic ovf16(input int v);
        return (v > 32767) || (v < -32768);
    endfunction

    // Reference model: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [4:0] op, input logic [15:0] av, input logic [15:0] bv);
        exp_t    e;
        longint  ua, ub, t;
        int      sa, sb;
        ua = longint'(av);
        ub = longint'(bv);
        sa = int'($signed(av));
        sb = int'($signed(bv));
        e  = '0;
        case (op)
            5'd0: begin
                t = ua + ub;
                e.r = t[15:0];
                e.c = (t > 65535);
                e.o = ovf16(sa + sb);
            end
            5'd1: begin
                t = ua - ub;
                e.r = t[15:0];
                e.c = (ua < ub);
                e.o = ovf16(sa - sb);
            end
            5'd2: begin
                t = ua * ub;
                e.r = t[15:0];
            end
`ifdef ALU_DIV_EN
            5'd3: e.r = (ub == 0) ? 16'h0 : 16'(ua / ub);
            5'd4: e.r = (ub == 0) ? 16'h0 : 16'(ua % ub);
`endif
            5'd5:  e.r = av & bv;
            5'd6:  e.r = av | bv;
            5'd7:  e.r = av ^ bv;
            5'd8:  e.r = ~(av & bv);
            5'd9:  e.r = ~(av | bv);
            5'd10: e.r = ~(av ^ bv);
            5'd11: e.r = ~av;
            5'd12: begin t = 65536 - ua; e.r = t[15:0]; end
            5'd13: begin t = ua * (longint'(1) << (ub >= 16 ? 16 : ub)); e.r = t[15:0]; end
            5'd14: e.r = (ub >= 16) ? 16'h0 : 16'(ua / (longint'(1) << ub));
            5'd15: e.r = (ub >= 16) ? ((sa < 0) ? 16'hFFFF : 16'h0) : 16'(sa >>> ub);
            5'd16: e.r = (sa < sb) ? 16'd1 : 16'd0;
            5'd17: e.r = (ua < ub) ? 16'd1 : 16'd0;
            5'd18: begin t = ua + 1; e.r = t[15:0]; e.c = (ua == 65535); end
            5'd19: begin t = ua + 65535; e.r = t[15:0]; e.c = (ua == 0); end
            5'd20: begin t = ua * 2 + ua / 32768; e.r = t[15:0]; end
            5'd21: begin t = ua / 2 + (ua % 2) * 32768; e.r = t[15:0]; end
            5'd22: e.r = av;
            5'd23: e.r = bv;
            default: e = '0;
        endcase
        e.z = (e.r == 16'h0);
        return e;
    endfunction

    // Expected outputs for the edge just taken, compared at the next falling edge.
    exp_t exp_q;
    bit   exp_v = 1'b0;

    always @(posedge clk) begin
        if (rst) exp_q <= '{r: 16'h0, z: 1'b1, c: 1'b0, o: 1'b0};
        else     exp_q <= model(bus.opcode, bus.a, bus.b);
        exp_v <= 1'b1;
    end

    always @(negedge clk) begin
        if (exp_v) begin
            checks++;
            if ({bus.result, bus.zero, bus.carry_out, bus.overflow} !== exp_q) begin
                errors++;
                $display("FAIL model t=%0t: got r=%h z=%b c=%b o=%b want r=%h z=%b c=%b o=%b",
                         $time, bus.result, bus.zero, bus.carry_out, bus.overflow,
                         exp_q.r, exp_q.z, exp_q.c, exp_q.o);
            end
        end
    end

    task automatic pin(input string nm, input logic [15:0] er, input logic ez, input logic ec, input logic eo);
        checks++;
        if (bus.result !== er || bus.zero !== ez || bus.carry_out !== ec || bus.overflow !== eo) begin
            errors++;
            $display("FAIL %s: got r=%h z=%b c=%b o=%b want r=%h z=%b c=%b o=%b",
                     nm, bus.result, bus.zero, bus.carry_out, bus.overflow, er, ez, ec, eo);
        end
    endtask

    // Applies one operation at the falling edge and checks it just after the
    // next rising edge; consecutive calls issue one operation per cycle.
    task automatic vec(input string nm, input logic [4:0] op, input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] er, input logic ez, input logic ec, input logic eo);
        @(negedge clk);
        rst = 1'b0;
        bus.opcode = op;
        bus.a = av;
        bus.b = bv;
        @(posedge clk);
        #1;
        pin(nm, er, ez, ec, eo);
    endtask

    initial begin
        bus.a = 16'(($urandom));
        bus.b = 16'(($urandom));
        bus.opcode = 5'(($urandom));
        rst = 1'b1;
        @(posedge clk); #1;
        pin("reset_1", 16'h0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        bus.a = 16'(($urandom));
        bus.opcode = OP_PASSA;
        @(posedge clk); #1;
        pin("reset_2", 16'h0000, 1'b1, 1'b0, 1'b0);

        vec("add_carry",  OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0);
        vec("add_ovf",    OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 1);
        vec("sub_borrow", OP_SUB, 16'h0030, 16'h0040, 16'hFFF0, 0, 1, 0);
        vec("sub_ovf",    OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 1);
        vec("mul_wrap",   OP_MUL, 16'h0100, 16'h0100, 16'h0000, 1, 0, 0);
`ifdef ALU_DIV_EN
        vec("div",        OP_DIV, 16'h0064, 16'h000A, 16'h000A, 0, 0, 0);
        vec("mod",        OP_MOD, 16'h0065, 16'h000A, 16'h0001, 0, 0, 0);
        vec("div_zero",   OP_DIV, 16'h0064, 16'h0000, 16'h0000, 1, 0, 0);
`else
        vec("div_off",    OP_DIV, 16'h0064, 16'h000A, 16'h0000, 1, 0, 0);
        vec("mod_off",    OP_MOD, 16'h0065, 16'h000A, 16'h0000, 1, 0, 0);
`endif
        vec("and_zero",   OP_AND, 16'hAAAA, 16'h5555, 16'h0000, 1, 0, 0);
        vec("nor",        OP_NOR, 16'h0000, 16'h0000, 16'hFFFF, 0, 0, 0);
        vec("neg",        OP_NEG, 16'h0001, 16'h0000, 16'hFFFF, 0, 0, 0);
        vec("sll",        OP_SLL, 16'h0001, 16'h0004, 16'h0010, 0, 0, 0);
        vec("sra",        OP_SRA, 16'h8000, 16'h0004, 16'hF800, 0, 0, 0);
        vec("srl",        OP_SRL, 16'h0080, 16'h0004, 16'h0008, 0, 0, 0);
        vec("sra_big",    OP_SRA, 16'h8000, 16'd20,   16'hFFFF, 0, 0, 0);
        vec("sll_big",    OP_SLL, 16'hFFFF, 16'd16,   16'h0000, 1, 0, 0);
        vec("slt",        OP_SLT, 16'hFFFE, 16'h0001, 16'h0001, 0, 0, 0);
        vec("sltu",       OP_SLTU, 16'hFFFE, 16'h0001, 16'h0000, 1, 0, 0);
        vec("inc_wrap",   OP_INC, 16'hFFFF, 16'h0000, 16'h0000, 1, 1, 0);
        vec("dec_wrap",   OP_DEC, 16'h0000, 16'h0000, 16'hFFFF, 0, 1, 0);
        vec("rotl",       OP_ROTL, 16'h8001, 16'h0000, 16'h0003, 0, 0, 0);
        vec("rotr",       OP_ROTR, 16'h8001, 16'h0000, 16'hC000, 0, 0, 0);
        vec("pass_a",     OP_PASSA, 16'hF4D0, 16'h1234, 16'hF4D0, 0, 0, 0);
        vec("pass_b",     OP_PASSB, 16'h1234, 16'h0050, 16'h0050, 0, 0, 0);
        vec("reserved",   5'b11000, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 0, 0);

        // Mid-stream reset clears a non-zero result on the next edge.
        vec("pre_reset",  OP_PASSA, 16'hBEEF, 16'h0000, 16'hBEEF, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        bus.opcode = OP_ADD;
        bus.a = 16'hFFFF;
        bus.b = 16'h0001;
        @(posedge clk); #1;
        pin("mid_reset", 16'h0000, 1'b1, 1'b0, 1'b0);

        // Randomized run, checked each cycle by the model compare process.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 63) == 0);
            bus.opcode = 5'($urandom_range(0, 31));
            bus.a = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       bus.b = 16'($urandom_range(0, 20));
                1:       bus.b = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'hFFFF;
                default: bus.b = 16'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) bus.a = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'hFFFF;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
